// File: rtl/k_merge_p2_if.sv
// k_merge_p2 bus: phase 1 head inputs, pop strobes
// and the merged-result valid/ready stream.
interface k_merge_p2_if #(
  parameter int VAL_WIDTH = 32,
  parameter int NUM_CH    = 4
);
  logic                        start;
  logic [NUM_CH*32-1:0]        chNameIn;
  logic [NUM_CH*VAL_WIDTH-1:0] chValueIn;
  logic [NUM_CH-1:0]           chOutEn;
  logic                        resultValid;
  logic                        resultReady;
  logic [31:0]                 resultName;
  logic [VAL_WIDTH-1:0]        resultValue;
  logic                        busy;
  logic                        mergeDone;

  modport master (
    output start, chNameIn, chValueIn, resultReady,
    input  chOutEn, resultValid, resultName, resultValue,
    input  busy, mergeDone
  );

  modport slave (
    input  start, chNameIn, chValueIn, resultReady,
    output chOutEn, resultValid, resultName, resultValue,
    output busy, mergeDone
  );
endinterface

// File: rtl/k_merge_p2.sv
// KNN phase 2: merges NUM_CH ascending K-lists
// into one global ascending K-best stream.
module k_merge_p2 #(
  parameter int VAL_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int K         = 4
) (
  input logic        clk,
  input logic        reset,
  k_merge_p2_if.slave bus
);
  localparam int CW = $clog2(K + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE, SELECT, EMIT, POP, DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]        cnt [NUM_CH];
  logic [CW-1:0]        out_cnt;
  logic [IW-1:0]        win_idx;
  logic [31:0]          win_name;
  logic [VAL_WIDTH-1:0] win_val;
  logic [IW-1:0]        sel_idx;
  logic [31:0]          sel_name;
  logic [VAL_WIDTH-1:0] sel_val;
  logic                 sel_ok;
  logic                 st_sel;
  logic                 st_acc;
  logic                 st_arm;

  assign st_sel = (state == SELECT);
  assign st_acc = (state == EMIT) && bus.resultReady;
  assign st_arm = ((state == IDLE) || (state == DONE))
                  && bus.start;

  // Minimum head among live channels; strict < keeps ties
  // on the lowest channel index.
  always_comb begin
    sel_ok   = 1'b0;
    sel_idx  = '0;
    sel_name = bus.chNameIn[31:0];
    sel_val  = bus.chValueIn[VAL_WIDTH-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt[c] != CW'(K)) begin
        if (!sel_ok ||
            bus.chValueIn[c*VAL_WIDTH +: VAL_WIDTH] < sel_val) begin
          sel_ok   = 1'b1;
          sel_idx  = IW'(c);
          sel_name = bus.chNameIn[c*32 +: 32];
          sel_val  = bus.chValueIn[c*VAL_WIDTH +: VAL_WIDTH];
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = SELECT;
      SELECT:  state_nx = EMIT;
      EMIT:    if (bus.resultReady) state_nx = POP;
      POP:     state_nx = (out_cnt == CW'(K)) ? DONE : SELECT;
      DONE:    if (bus.start) state_nx = SELECT;
      default: state_nx = IDLE;
    endcase
  end

  // Winner capture and per-channel consumption counters;
  // cnt tracks exhaustion since the phase 1 pointer saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_idx  <= '0;
      win_name <= '0;
      win_val  <= '0;
      out_cnt  <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      unique case (1'b1)
        st_sel: begin
          win_idx  <= sel_idx;
          win_name <= sel_name;
          win_val  <= sel_val;
        end
        st_acc: begin
          cnt[win_idx] <= cnt[win_idx] + CW'(1);
          out_cnt      <= out_cnt + CW'(1);
        end
        st_arm: begin
          out_cnt <= '0;
          for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resultValid = (state == EMIT);
  assign bus.resultName  = win_name;
  assign bus.resultValue = win_val;
  assign bus.busy        = (state == SELECT) ||
                           (state == EMIT) ||
                           (state == POP);
  assign bus.mergeDone   = (state == DONE);
  assign bus.chOutEn     = (state == POP) ?
                           (NUM_CH'(1) << win_idx) : '0;
endmodule

// File: tb/tb_k_merge_p2.sv
// Bench for k_merge_p2: phase 1 list model plus
// scoreboard of expected merged entries and pops.
module tb_k_merge_p2;
  localparam int VW = 32;
  localparam int NC = 2;
  localparam int K  = 4;

  typedef struct {
    logic [31:0]   name;
    logic [VW-1:0] val;
  } res_t;

  logic clk;
  logic rst_n;
  logic p1_clr;
  logic chk_gap;
  int   cyc = 0;
  int   start_cyc = 0;
  int   merge_id = 0;
  int   hs_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ptr [NC];

  logic [VW-1:0] lval  [NC][K];
  logic [31:0]   lname [NC][K];

  res_t exp_q [$];
  int   exp_ch [$];

  k_merge_p2_if #(.VAL_WIDTH(VW), .NUM_CH(NC)) bus ();

  k_merge_p2 #(.VAL_WIDTH(VW), .NUM_CH(NC), .K(K)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Phase 1 head presentation.
  always_comb begin
    bus.chValueIn = '0;
    bus.chNameIn  = '0;
    for (int c = 0; c < NC; c++) begin
      bus.chValueIn[c*VW +: VW] = lval[c][ptr[c]];
      bus.chNameIn[c*32 +: 32]  = lname[c][ptr[c]];
    end
  end

  // Phase 1 pointers: advance on pop, saturate at K-1.
  initial begin
    for (int c = 0; c < NC; c++) ptr[c] = 0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      for (int c = 0; c < NC; c++) begin
        if (p1_clr) ptr[c] <= 0;
        else if (bus.chOutEn[c] && ptr[c] < K - 1)
          ptr[c] <= ptr[c] + 1;
      end
    end
  end

  // Output monitor: scoreboard pops, pop strobes, spacing.
  initial begin
    int   mon_id;
    bit   seen_v;
    bit   done_seen;
    int   last_hs;
    int   ch;
    res_t e;
    mon_id = 0; seen_v = 0; done_seen = 0; last_hs = 0;
    forever begin
      @(negedge clk);
      if (mon_id != merge_id) begin
        mon_id = merge_id; hs_cnt = 0;
        seen_v = 0; done_seen = 0;
      end
      if (bus.resultValid && !seen_v) begin
        seen_v = 1;
        chk("first_lat", 64'(cyc - start_cyc), 64'(2));
      end
      if (bus.chOutEn != '0) begin
        if (exp_ch.size() == 0)
          chk("pop_extra", 64'(bus.chOutEn), 64'(0));
        else begin
          ch = exp_ch.pop_front();
          chk("pop_ch", 64'(bus.chOutEn), 64'(1) << ch);
        end
      end
      if (bus.resultValid && bus.resultReady) begin
        if (exp_q.size() == 0)
          chk("res_extra", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("res_name", 64'(bus.resultName), 64'(e.name));
          chk("res_val", 64'(bus.resultValue), 64'(e.val));
        end
        if (chk_gap && hs_cnt > 0)
          chk("res_gap", 64'(cyc - last_hs), 64'(3));
        last_hs = cyc;
        hs_cnt++;
      end
      if (bus.mergeDone && !done_seen) begin
        done_seen = 1;
        chk("done_after", 64'(hs_cnt), 64'(K));
      end
    end
  end

  task automatic load(input int c,
                      input logic [VW-1:0] v0, v1, v2, v3,
                      input logic [31:0] n0, n1, n2, n3);
    lval[c][0] = v0; lval[c][1] = v1;
    lval[c][2] = v2; lval[c][3] = v3;
    lname[c][0] = n0; lname[c][1] = n1;
    lname[c][2] = n2; lname[c][3] = n3;
  endtask

  task automatic clear_p1();
    @(posedge clk); #1;
    p1_clr = 1'b1;
    @(posedge clk); #1;
    p1_clr = 1'b0;
  endtask

  // Reference: K smallest by (value, channel, position).
  task automatic expect_merge();
    bit   used [NC][K];
    int   bc;
    int   bp;
    res_t r;
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < K; p++) used[c][p] = 0;
    for (int n = 0; n < K; n++) begin
      bc = -1; bp = 0;
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < K; p++)
          if (!used[c][p] &&
              (bc < 0 || lval[c][p] < lval[bc][bp])) begin
            bc = c; bp = p;
          end
      used[bc][bp] = 1;
      r.name = lname[bc][bp];
      r.val  = lval[bc][bp];
      exp_q.push_back(r);
      exp_ch.push_back(bc);
    end
  endtask

  task automatic start_merge();
    @(posedge clk); #1;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    merge_id++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.mergeDone && n < 300) begin
      @(negedge clk); n++;
    end
    chk("done_timeout", 64'(bus.mergeDone), 64'(1));
    chk("q_empty", 64'(exp_q.size()), 64'(0));
    chk("busy_done", 64'(bus.busy), 64'(0));
    chk("valid_done", 64'(bus.resultValid), 64'(0));
  endtask

  task automatic load_basic();
    load(0, 1, 5, 9, 13, 0, 2, 4, 6);
    load(1, 2, 3, 20, 30, 1, 3, 5, 7);
  endtask

  task automatic load_tie();
    load(0, 7, 8, 10, 11, 10, 11, 12, 13);
    load(1, 7, 9, 12, 13, 20, 21, 22, 23);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.resultReady = 1'b1;
    p1_clr = 1'b0;
    chk_gap = 1'b1;
    load_basic();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outen", 64'(bus.chOutEn), 64'(0));
    chk("rst_valid", 64'(bus.resultValid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.mergeDone), 64'(0));
    chk("rst_name", 64'(bus.resultName), 64'(0));
    chk("rst_value", 64'(bus.resultValue), 64'(0));
    rst_n = 1'b1;

    // basic merge
    clear_p1();
    expect_merge();
    start_merge();
    chk("busy_run", 64'(bus.busy), 64'(1));
    wait_done();

    // tie break on the lowest channel
    load_tie();
    clear_p1();
    expect_merge();
    start_merge();
    wait_done();

    // backpressure
    chk_gap = 1'b0;
    load_basic();
    clear_p1();
    expect_merge();
    bus.resultReady = 1'b0;
    start_merge();
    n = 0;
    while (!bus.resultValid && n < 50) begin
      @(negedge clk); n++;
    end
    chk("bp_valid_up", 64'(bus.resultValid), 64'(1));
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.resultValid), 64'(1));
      chk("bp_name", 64'(bus.resultName), 64'(exp_q[0].name));
      chk("bp_value", 64'(bus.resultValue), 64'(exp_q[0].val));
      chk("bp_outen", 64'(bus.chOutEn), 64'(0));
    end
    @(posedge clk); #1;
    bus.resultReady = 1'b1;
    wait_done();
    chk_gap = 1'b1;

    // sentinel padding
    load(0, 4, 6, '1, '1, 40, 41, 32'hFFFFFFFF, 32'hFFFFFFFF);
    load(1, '1, '1, '1, '1, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'hFFFFFFFF, 32'hFFFFFFFF);
    clear_p1();
    expect_merge();
    start_merge();
    wait_done();

    // start pulse during POP is ignored
    load_tie();
    clear_p1();
    expect_merge();
    start_merge();
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (bus.chOutEn == '0 && n < 50);
    chk("pop_seen", 64'(bus.chOutEn != '0), 64'(1));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();

    // reset mid-merge
    load_basic();
    clear_p1();
    expect_merge();
    start_merge();
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (hs_cnt < 2 && n < 50);
    chk("two_results", 64'(hs_cnt), 64'(2));
    @(posedge clk); #1;
    bus.resultReady = 1'b0;
    n = 0;
    while (!bus.resultValid && n < 50) begin
      @(negedge clk); n++;
    end
    chk("emit_before_rst", 64'(bus.resultValid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.resultValid), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_outen", 64'(bus.chOutEn), 64'(0));
    chk("arst_done", 64'(bus.mergeDone), 64'(0));
    exp_q.delete();
    exp_ch.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resultReady = 1'b1;
    clear_p1();
    expect_merge();
    start_merge();
    wait_done();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/k_merge_p2.md
Name: k_merge_p2

Overview:
- Phase 2 of KNN sorting. Sits directly downstream of the NUM_CH phase 1 per-channel sorters.
- Once all channels have finished, it merges the NUM_CH ascending K-lists into one global ascending K-best list.
- Each channel's current head entry is read and popped through that channel's outEn line.
- Merged results stream out one per valid/ready handshake.

Parameters:
- VAL_WIDTH, 32, width of each distance value.
- NUM_CH, 4, number of phase 1 channels feeding this block.
- K, 4, neighbours kept per channel and total results emitted.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: all phase 1 lists are complete; begin merging.
- chNameIn  in  NUM_CH*32  concatenated head names; channel c occupies bits [c*32 +: 32].
- chValueIn  in  NUM_CH*VAL_WIDTH  concatenated head values; channel c occupies bits [c*VAL_WIDTH +: VAL_WIDTH].
- chOutEn  out  NUM_CH  one-hot, one-cycle pop pulse to a phase 1 channel's outEn.
- resultValid  out  1  resultName/resultValue hold a valid merged entry.
- resultReady  in  1  downstream accepts the entry this cycle.
- resultName  out  32  name (ID) of the current merged entry.
- resultValue  out  VAL_WIDTH  distance of the current merged entry.
- busy  out  1  high in SELECT, EMIT and POP.
- mergeDone  out  1  high while in DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; per-channel counters cnt[c]=0; outCount=0.
- Counter widths are $clog2(K+1) bits.
- Channel c is exhausted when cnt[c]==K. This count is tracked locally because the phase 1 pointer saturates at K-1.
- The min selector is combinational:
  - It picks the minimum chValueIn among non-exhausted channels, using an unsigned compare.
  - Ties go to the lowest channel index.
- IDLE:
  - start=1 -> SELECT.
  - start=0 -> stay.
- SELECT (1 cycle):
  - Register the winning index, name and value.
  - -> EMIT.
- EMIT:
  - resultValid=1; resultName/resultValue driven from the registered winner and held stable.
  - resultReady=0 -> stay; no pops.
  - resultReady=1 -> POP; cnt[win]++, outCount++.
- POP (1 cycle):
  - chOutEn[win]=1 and all other chOutEn bits 0; resultValid=0.
  - The phase 1 pointer advances at the end of this cycle, so the new head is stable by the following SELECT.
  - outCount==K -> DONE; otherwise -> SELECT.
- DONE:
  - mergeDone=1, busy=0, resultValid=0.
  - start=1 -> clear cnt[] and outCount, then -> SELECT. Resetting phase 1 is the caller's responsibility.
- Throughput: 3 cycles per result with resultReady held high. Latency from start to the first resultValid is 2 cycles.
- Exactly K results are emitted per merge, because NUM_CH*K >= K.
- Sentinel entries (value all ones, name 32'hFFFFFFFF) from under-filled channels are emitted unchanged, like any other entry.
- start is ignored in SELECT, EMIT and POP.
- Reset asserted mid-merge returns the block to IDLE immediately, with chOutEn cleared asynchronously.
- NUM_CH=1 degenerates to a pass-through of channel 0's K entries in order.

Test Plan:
- Basic merge: NUM_CH=2, K=4, ch0 values {1,5,9,13} names {0,2,4,6}, ch1 values {2,3,20,30} names {1,3,5,7}, resultReady=1.
  -> Results (name,value) in order: (0,1), (1,2), (3,3), (2,5).
  -> chOutEn pulses in order: ch0, ch1, ch1, ch0.
  -> mergeDone rises after the 4th handshake.
  -> Results spaced 3 cycles apart; first resultValid 2 cycles after start.
- Tie: ch0={7,8,..}, ch1={7,9,..}.
  -> First result comes from ch0 (value 7); second is ch1's 7, before 8.
- Backpressure: hold resultReady=0 for 5 cycles during EMIT.
  -> resultValid stays 1; name/value stay stable; chOutEn stays 0.
  -> Completes normally once resultReady=1.
- Sentinel: ch0 has only 2 real entries {4,6}, padded with all-ones; ch1 is all sentinels; K=4.
  -> Results: 4, 6, all-ones(ch0), all-ones(ch0).
- Reset mid-merge: assert reset while in EMIT after 2 results.
  -> resultValid, busy and chOutEn go to 0 asynchronously; state=IDLE.
  -> After reset deasserts with phase 1 re-run, a fresh start yields the full correct 4-result sequence.
- start while busy: pulse start during POP.
  -> Ignored; outCount is not cleared; exactly K results are still produced.
